// File: rtl/pwm_car4_core.sv
// pwm_car4_core
//   Four-channel H-bridge PWM generator. Each 32-bit configuration word is
//   turned into a (pwm, in1, in2) drive triple. Configuration is shadowed and
//   only takes effect on period boundaries. A reversal of direction on an
//   enabled channel inserts DEAD_PERIODS full periods of forced-off time.
//
// Parameters
//   PRESCALE      ACLK cycles per counter tick (>= 1)
//   PERIOD        counter ticks per PWM period (2..65535)
//   DEAD_PERIODS  forced-off periods on a direction change (0 = immediate)
//
// Ports
//   ACLK         clock, rising edge
//   ARESET       synchronous active-high reset
//   cfg0..cfg3   [15:0] duty ticks, [16] dir, [17] brake, [31] enable
//   pwm          PWM output per channel (bit n <- cfgn)
//   in1, in2     H-bridge inputs per channel
//   period_tick  one-cycle pulse at the start of each period
module pwm_car4_core #(
  parameter int PRESCALE     = 4,
  parameter int PERIOD       = 2500,
  parameter int DEAD_PERIODS = 2
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic [31:0] cfg0,
  input  logic [31:0] cfg1,
  input  logic [31:0] cfg2,
  input  logic [31:0] cfg3,
  output logic [3:0]  pwm,
  output logic [3:0]  in1,
  output logic [3:0]  in2,
  output logic        period_tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DW = (DEAD_PERIODS > 0) ? $clog2(DEAD_PERIODS + 1) : 1;

  localparam logic [PW-1:0] PRE_LAST  = PW'(PRESCALE - 1);
  localparam logic [15:0]   CNT_LAST  = 16'(PERIOD - 1);
  localparam logic [15:0]   PERIOD_W  = 16'(PERIOD);
  localparam logic [DW-1:0] DEAD_INIT = DW'(DEAD_PERIODS);

  typedef enum logic {RUN, DEAD} state_t;

  // Only the fields the generator acts on are kept in the shadow.
  typedef struct packed {
    logic        enable;
    logic        brake;
    logic        dir;
    logic [15:0] duty;
  } chan_cfg_t;

  // ---------------------------------------------------------------------
  // Timebase
  // ---------------------------------------------------------------------
  logic [PW-1:0] pre_cnt;
  logic [15:0]   cnt;
  logic          load_en;

  // NOTE: sequential state is always assigned with <= so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      pre_cnt <= '0;
      cnt     <= '0;
    end else if (pre_cnt == PRE_LAST) begin
      pre_cnt <= '0;
      cnt     <= (cnt == CNT_LAST) ? 16'd0 : cnt + 16'd1;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  assign load_en = (pre_cnt == '0) && (cnt == 16'd0);

  // ---------------------------------------------------------------------
  // Configuration shadowing
  // ---------------------------------------------------------------------
  chan_cfg_t cfg_in [4];
  chan_cfg_t shadow [4];
  chan_cfg_t eff    [4];

  assign cfg_in[0] = '{enable: cfg0[31], brake: cfg0[17], dir: cfg0[16], duty: cfg0[15:0]};
  assign cfg_in[1] = '{enable: cfg1[31], brake: cfg1[17], dir: cfg1[16], duty: cfg1[15:0]};
  assign cfg_in[2] = '{enable: cfg2[31], brake: cfg2[17], dir: cfg2[16], duty: cfg2[15:0]};
  assign cfg_in[3] = '{enable: cfg3[31], brake: cfg3[17], dir: cfg3[16], duty: cfg3[15:0]};

  // Reserved configuration bits are intentionally ignored.
  logic unused_cfg_bits;
  assign unused_cfg_bits = ^{cfg0[30:18], cfg1[30:18], cfg2[30:18], cfg3[30:18]};

  // NOTE: the shadow array is a handful of flops, not a RAM, so it is
  // cleared on reset like any other state.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int i = 0; i < 4; i++) shadow[i] <= '0;
    end else if (load_en) begin
      for (int i = 0; i < 4; i++) shadow[i] <= cfg_in[i];
    end
  end

  // On the boundary cycle the incoming word is what is being captured, so
  // the FSM and the registered outputs act on it directly; this keeps the
  // first period's outputs aligned one cycle after load_en.
  always_comb begin
    for (int i = 0; i < 4; i++) eff[i] = load_en ? cfg_in[i] : shadow[i];
  end

  // ---------------------------------------------------------------------
  // Per-channel direction FSM and output decode
  // ---------------------------------------------------------------------
  state_t        state     [4];
  state_t        state_nxt [4];
  logic [DW-1:0] dead_cnt     [4];
  logic [DW-1:0] dead_cnt_nxt [4];
  logic [3:0]    adir, adir_nxt;
  logic [3:0]    pwm_nxt, in1_nxt, in2_nxt;
  logic [15:0]   duty_sat [4];

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    adir_nxt = adir;
    pwm_nxt  = '0;
    in1_nxt  = '0;
    in2_nxt  = '0;
    for (int i = 0; i < 4; i++) begin
      state_nxt[i]    = state[i];
      dead_cnt_nxt[i] = dead_cnt[i];
      duty_sat[i]     = (eff[i].duty > PERIOD_W) ? PERIOD_W : eff[i].duty;

      if (load_en) begin
        if (!eff[i].enable) begin
          // Coming from off needs no dead time.
          state_nxt[i]    = RUN;
          adir_nxt[i]     = eff[i].dir;
          dead_cnt_nxt[i] = '0;
        end else if (state[i] == RUN) begin
          if (eff[i].dir != adir[i]) begin
            if (DEAD_PERIODS > 0) begin
              state_nxt[i]    = DEAD;
              dead_cnt_nxt[i] = DEAD_INIT;
            end else begin
              adir_nxt[i] = eff[i].dir;
            end
          end
        end else begin
          if (eff[i].dir == adir[i]) begin
            // Reversal withdrawn: resume in the old direction.
            state_nxt[i]    = RUN;
            dead_cnt_nxt[i] = '0;
          end else if (dead_cnt[i] <= DW'(1)) begin
            state_nxt[i]    = RUN;
            adir_nxt[i]     = eff[i].dir;
            dead_cnt_nxt[i] = '0;
          end else begin
            dead_cnt_nxt[i] = dead_cnt[i] - DW'(1);
          end
        end
      end

      // Decode from the next state so outputs follow it with one cycle of
      // latency through the output registers.
      if (!eff[i].enable || state_nxt[i] == DEAD) begin
        pwm_nxt[i] = 1'b0;
        in1_nxt[i] = 1'b0;
        in2_nxt[i] = 1'b0;
      end else if (eff[i].brake) begin
        pwm_nxt[i] = 1'b1;
        in1_nxt[i] = 1'b1;
        in2_nxt[i] = 1'b1;
      end else begin
        pwm_nxt[i] = (cnt < duty_sat[i]);
        in1_nxt[i] = adir_nxt[i];
        in2_nxt[i] = ~adir_nxt[i];
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int i = 0; i < 4; i++) begin
        state[i]    <= RUN;
        dead_cnt[i] <= '0;
      end
      adir        <= '0;
      pwm         <= '0;
      in1         <= '0;
      in2         <= '0;
      period_tick <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        state[i]    <= state_nxt[i];
        dead_cnt[i] <= dead_cnt_nxt[i];
      end
      adir        <= adir_nxt;
      pwm         <= pwm_nxt;
      in1         <= in1_nxt;
      in2         <= in2_nxt;
      period_tick <= load_en;
    end
  end

endmodule
